data_mem_ctrl: RTL and testbench
================================

# data_mem_ctrl

Data-memory responder for the single-issue RISC-V core. It services the `mem_read`/`mem_write` requests raised by the decode/control path for load and store instructions. It holds a word-organised on-chip RAM, applies RV32I byte/half/word sizing and load sign-extension, inserts a configurable number of wait states, and returns a one-cycle `ready` pulse that the core uses to release its stall.

## Interface
- `ADDR_WIDTH`, default 10: word-address width. RAM depth is 2^ADDR_WIDTH 32-bit words.
- `WAIT_CYCLES`, default 1: wait states between request acceptance and response. Legal range 0..15.

- `clk`  in  1  system clock, rising edge
- `rst_n`  in  1  reset, asynchronous, active-low
- `mem_read`  in  1  load request, held by core until `ready`
- `mem_write`  in  1  store request, held by core until `ready`
- `addr`  in  32  byte address (ALU result)
- `wdata`  in  32  store data (rs2), lower bits used for SB/SH
- `funct3`  in  3  access size/sign from instruction
- `rdata`  out  32  load result, sized and extended, valid when `ready`=1
- `ready`  out  1  one-cycle completion pulse
- `err`  out  1  valid with `ready`: misaligned access or illegal funct3
- `busy`  out  1  high whenever the FSM is not in IDLE

## Operation
- FSM states: IDLE, WAIT, RESP.
- IDLE: a request is accepted on a rising edge where `mem_read|mem_write`=1. On acceptance, `addr`, `wdata`, `funct3` and the direction are captured. If both request lines are high, the access is a write.
  - Go to WAIT with counter = WAIT_CYCLES-1 when WAIT_CYCLES>0; otherwise go directly to RESP.
- WAIT: the counter decrements each cycle. At 0, go to RESP.
- Entering RESP performs the access on the same edge. `ready`=1 for exactly the RESP cycle. RESP always returns to IDLE on the next edge.
- The core must deassert its request in the RESP cycle. A request still asserted in the following IDLE cycle is a new access.
- Word index = `addr[ADDR_WIDTH+1:2]`. Upper address bits are ignored, so accesses wrap modulo RAM size.
- Loads:
  - funct3 000 LB: sign-extend the byte.
  - funct3 100 LBU: zero-extend the byte.
  - funct3 001 LH: sign-extend the half.
  - funct3 101 LHU: zero-extend the half.
  - funct3 010 LW: full word.
  - Byte lane is selected by `addr[1:0]`; half lane by `addr[1]`.
- Stores:
  - funct3 000 SB writes one lane from `wdata[7:0]`.
  - funct3 001 SH writes one half from `wdata[15:0]`.
  - funct3 010 SW writes the full word.
  - Unwritten lanes are preserved.
- Error cases: a half access with `addr[0]`=1, a word access with `addr[1:0]`≠0, or any other funct3 value gives `err`=1 in RESP.
  - No RAM write occurs.
  - `rdata`=0.
  - Wait states are still honoured.
- RAM contents are not reset and are undefined until written.

## Timing
- Reset values: `rdata`=0, `ready`=0, `err`=0, `busy`=0, state IDLE, counter 0.
- Latency from the acceptance edge to `ready` high is WAIT_CYCLES+1 cycles. With WAIT_CYCLES=0, `ready` is high in the cycle after acceptance.
- `rdata` and `err` are registered. They are valid only while `ready`=1 and hold their value until the next response.
- `busy` is high from the cycle after acceptance through the RESP cycle. Maximum throughput is one access per WAIT_CYCLES+2 cycles.
- Request inputs are ignored in WAIT and RESP. Captured values are used, so input changes mid-access have no effect.
- Reset asserted in WAIT: return to IDLE immediately, force outputs low, and commit no write. Reset asserted on the RESP-entry edge: the write state is indeterminate, and the bench must not check that case.

## Test plan
- SW 0xDEADBEEF to 0x10, then LW 0x10: `rdata`=0xDEADBEEF, `err`=0, `ready` two cycles after acceptance (WAIT_CYCLES=1).
- SB 0x80 to 0x13, then LB 0x13 gives 0xFFFFFF80, LBU 0x13 gives 0x00000080, and LW 0x10 gives 0x80ADBEEF (other lanes preserved).
- LW 0x12 and SH 0x11: `err`=1 with `ready`; a following LW 0x10 shows memory unchanged. funct3=011: `err`=1.
- WAIT_CYCLES=0 back-to-back: SW then LW with the request held one cycle longer. `ready` pulses every 2 cycles, `busy` toggles accordingly, and no duplicate access occurs.
- Wrap: with ADDR_WIDTH=10, SW 0x1234 to 0x1000, then LW 0x0000 returns 0x1234.
- Assert `rst_n`=0 during WAIT of SW 0x55 to 0x20: outputs go to 0 asynchronously, and a later LW 0x20 does not return 0x55.

Source files
------------

// File: rtl/data_mem_ctrl.sv
// Data-memory responder for the RV32I core: word RAM with byte/half/word sizing,
// load sign-extension, programmable wait states and a one-cycle ready pulse.
module data_mem_ctrl #(
  parameter int ADDR_WIDTH  = 10,
  parameter int WAIT_CYCLES = 1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        mem_read,
  input  logic        mem_write,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  input  logic [2:0]  funct3,
  output logic [31:0] rdata,
  output logic        ready,
  output logic        err,
  output logic        busy
);

  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

  localparam int AW = ADDR_WIDTH + 2;
  localparam logic [3:0] CNT_INIT = (WAIT_CYCLES > 0) ? 4'(WAIT_CYCLES - 1) : 4'd0;

  state_t state, next_state;
  logic [3:0] cnt, cnt_next;

  logic [AW-1:0] cap_addr;
  logic [31:0]   cap_wdata;
  logic [2:0]    cap_funct3;
  logic          cap_write;

  logic [AW-1:0]         acc_addr;
  logic [31:0]           acc_wdata;
  logic [2:0]            acc_funct3;
  logic                  acc_write;
  logic                  acc_err;
  logic [ADDR_WIDTH-1:0] acc_idx;

  logic        accept;
  logic        do_access;
  logic        mem_we;
  logic [31:0] cur_word;
  logic [7:0]  byte_sel;
  logic [15:0] half_sel;
  logic [31:0] load_val;
  logic [31:0] store_word;
  logic [3:0]  byte_en;
  logic        unused_addr_bits;

  logic [31:0] mem [0:(1<<ADDR_WIDTH)-1];

  // Upper address bits are dropped on purpose so accesses wrap modulo RAM size.
  assign unused_addr_bits = ^addr[31:AW];

  assign accept = (state == IDLE) && (mem_read || mem_write);
  assign ready  = (state == RESP);
  assign busy   = (state != IDLE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      cnt   <= 4'd0;
    end else begin
      state <= next_state;
      cnt   <= cnt_next;
    end
  end

  always_comb begin
    next_state = state;
    cnt_next   = cnt;
    case (state)
      IDLE: begin
        if (accept) begin
          if (WAIT_CYCLES > 0) begin
            next_state = WAIT;
            cnt_next   = CNT_INIT;
          end else begin
            next_state = RESP;
          end
        end
      end
      WAIT: begin
        if (cnt == 4'd0) begin
          next_state = RESP;
        end else begin
          cnt_next = cnt - 4'd1;
        end
      end
      RESP:    next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cap_addr   <= '0;
      cap_wdata  <= 32'd0;
      cap_funct3 <= 3'd0;
      cap_write  <= 1'b0;
    end else if (accept) begin
      cap_addr   <= addr[AW-1:0];
      cap_wdata  <= wdata;
      cap_funct3 <= funct3;
      cap_write  <= mem_write;
    end
  end

  // With zero wait states RESP is entered on the acceptance edge itself,
  // so the access must come straight from the live inputs in that case.
  always_comb begin
    if (state == IDLE) begin
      acc_addr   = addr[AW-1:0];
      acc_wdata  = wdata;
      acc_funct3 = funct3;
      acc_write  = mem_write;
    end else begin
      acc_addr   = cap_addr;
      acc_wdata  = cap_wdata;
      acc_funct3 = cap_funct3;
      acc_write  = cap_write;
    end
  end

  assign acc_idx   = acc_addr[AW-1:2];
  assign do_access = (next_state == RESP) && (state != RESP);
  assign cur_word  = mem[acc_idx];

  always_comb begin
    acc_err = 1'b1;
    case (acc_funct3)
      3'b000:  acc_err = 1'b0;
      3'b001:  acc_err = acc_addr[0];
      3'b010:  acc_err = |acc_addr[1:0];
      3'b100:  acc_err = acc_write;
      3'b101:  acc_err = acc_write | acc_addr[0];
      default: acc_err = 1'b1;
    endcase
  end

  always_comb begin
    byte_sel = cur_word[7:0];
    case (acc_addr[1:0])
      2'd0:    byte_sel = cur_word[7:0];
      2'd1:    byte_sel = cur_word[15:8];
      2'd2:    byte_sel = cur_word[23:16];
      default: byte_sel = cur_word[31:24];
    endcase
    half_sel = acc_addr[1] ? cur_word[31:16] : cur_word[15:0];
    load_val = 32'd0;
    case (acc_funct3)
      3'b000:  load_val = {{24{byte_sel[7]}}, byte_sel};
      3'b100:  load_val = {24'd0, byte_sel};
      3'b001:  load_val = {{16{half_sel[15]}}, half_sel};
      3'b101:  load_val = {16'd0, half_sel};
      3'b010:  load_val = cur_word;
      default: load_val = 32'd0;
    endcase
  end

  // Store data is replicated across lanes so the byte enables alone pick the target.
  always_comb begin
    store_word = 32'd0;
    byte_en    = 4'b0000;
    case (acc_funct3)
      3'b000: begin
        store_word = {4{acc_wdata[7:0]}};
        byte_en    = 4'b0001 << acc_addr[1:0];
      end
      3'b001: begin
        store_word = {2{acc_wdata[15:0]}};
        byte_en    = acc_addr[1] ? 4'b1100 : 4'b0011;
      end
      3'b010: begin
        store_word = acc_wdata;
        byte_en    = 4'b1111;
      end
      default: begin
        store_word = 32'd0;
        byte_en    = 4'b0000;
      end
    endcase
  end

  assign mem_we = do_access && acc_write && !acc_err;

  always_ff @(posedge clk) begin
    if (mem_we) begin
      for (int i = 0; i < 4; i++) begin
        if (byte_en[i]) begin
          mem[acc_idx][8*i +: 8] <= store_word[8*i +: 8];
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rdata <= 32'd0;
      err   <= 1'b0;
    end else if (do_access) begin
      err   <= acc_err;
      rdata <= (acc_write || acc_err) ? 32'd0 : load_val;
    end
  end

endmodule

// File: tb/tb_data_mem_ctrl.sv
// Self-checking bench for data_mem_ctrl: one instance with a wait state, one with none,
// expected responses queued at request time and compared when ready pulses.
module tb_data_mem_ctrl;

  localparam int AW = 10;
  localparam int WC = 1;
  localparam logic [2:0] F_B  = 3'b000;
  localparam logic [2:0] F_H  = 3'b001;
  localparam logic [2:0] F_W  = 3'b010;
  localparam logic [2:0] F_BU = 3'b100;
  localparam logic [2:0] F_HU = 3'b101;

  typedef struct packed {
    logic [31:0] rdata;
    logic        err;
    logic        chk_data;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n;

  logic        mem_read, mem_write;
  logic [31:0] addr, wdata, rdata;
  logic [2:0]  funct3;
  logic        ready, err, busy;

  logic        z_mem_read, z_mem_write;
  logic [31:0] z_addr, z_wdata, z_rdata;
  logic [2:0]  z_funct3;
  logic        z_ready, z_err, z_busy;

  exp_t  q_main[$];
  string q_main_tag[$];
  exp_t  q_zero[$];
  string q_zero_tag[$];

  logic [1:0] z_pat [6] = '{2'b11, 2'b00, 2'b11, 2'b00, 2'b00, 2'b00};

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  data_mem_ctrl #(.ADDR_WIDTH(AW), .WAIT_CYCLES(WC)) dut (
    .clk(clk), .rst_n(rst_n), .mem_read(mem_read), .mem_write(mem_write),
    .addr(addr), .wdata(wdata), .funct3(funct3),
    .rdata(rdata), .ready(ready), .err(err), .busy(busy)
  );

  data_mem_ctrl #(.ADDR_WIDTH(AW), .WAIT_CYCLES(0)) dut_z (
    .clk(clk), .rst_n(rst_n), .mem_read(z_mem_read), .mem_write(z_mem_write),
    .addr(z_addr), .wdata(z_wdata), .funct3(z_funct3),
    .rdata(z_rdata), .ready(z_ready), .err(z_err), .busy(z_busy)
  );

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("[TB] FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  // Response monitors: every ready pulse must match the oldest queued expectation.
  always @(negedge clk) begin
    exp_t  e;
    string t;
    if (ready) begin
      if (q_main.size() == 0) begin
        checkOutput("main_unexpected_ready", 32'd1, 32'd0);
      end else begin
        e = q_main.pop_front();
        t = q_main_tag.pop_front();
        checkOutput({t, "_err"}, 32'(err), 32'(e.err));
        if (e.chk_data) checkOutput({t, "_rdata"}, rdata, e.rdata);
      end
    end
  end

  always @(negedge clk) begin
    exp_t  e;
    string t;
    if (z_ready) begin
      if (q_zero.size() == 0) begin
        checkOutput("zero_unexpected_ready", 32'd1, 32'd0);
      end else begin
        e = q_zero.pop_front();
        t = q_zero_tag.pop_front();
        checkOutput({t, "_err"}, 32'(z_err), 32'(e.err));
        if (e.chk_data) checkOutput({t, "_rdata"}, z_rdata, e.rdata);
      end
    end
  end

  task automatic applyStimulus(input string tag, input bit rd, input bit wr,
                               input logic [31:0] a, input logic [31:0] d,
                               input logic [2:0] f3, input logic [31:0] exp_rdata,
                               input bit exp_err);
    int   cycles;
    exp_t e;
    @(negedge clk);
    mem_read  = rd;
    mem_write = wr;
    addr      = a;
    wdata     = d;
    funct3    = f3;
    e.rdata    = exp_rdata;
    e.err      = exp_err;
    e.chk_data = (rd && !wr) || exp_err;
    q_main.push_back(e);
    q_main_tag.push_back(tag);
    @(posedge clk);
    cycles = 0;
    forever begin
      @(negedge clk);
      if (ready) break;
      cycles++;
      addr   = $urandom;
      wdata  = $urandom;
      funct3 = 3'($urandom);
      if (cycles > 40) break;
    end
    checkOutput({tag, "_latency"}, 32'(cycles + 1), 32'(WC + 1));
    mem_read  = 1'b0;
    mem_write = 1'b0;
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    exp_t e;
    rst_n = 1'b0;
    mem_read = 1'b0; mem_write = 1'b0; addr = 32'd0; wdata = 32'd0; funct3 = 3'd0;
    z_mem_read = 1'b0; z_mem_write = 1'b0; z_addr = 32'd0; z_wdata = 32'd0; z_funct3 = 3'd0;

    #12;
    checkOutput("reset_ready", 32'(ready), 32'd0);
    checkOutput("reset_err",   32'(err),   32'd0);
    checkOutput("reset_busy",  32'(busy),  32'd0);
    checkOutput("reset_rdata", rdata,      32'd0);
    checkOutput("reset_z_busy", 32'(z_busy), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    applyStimulus("sw_10",   0, 1, 32'h10, 32'hDEADBEEF, F_W,  32'h0,        0);
    applyStimulus("lw_10",   1, 0, 32'h10, 32'h0,        F_W,  32'hDEADBEEF, 0);
    applyStimulus("sb_13",   0, 1, 32'h13, 32'h12345680, F_B,  32'h0,        0);
    applyStimulus("lb_13",   1, 0, 32'h13, 32'h0,        F_B,  32'hFFFFFF80, 0);
    applyStimulus("lbu_13",  1, 0, 32'h13, 32'h0,        F_BU, 32'h00000080, 0);
    applyStimulus("lw_10b",  1, 0, 32'h10, 32'h0,        F_W,  32'h80ADBEEF, 0);
    applyStimulus("lh_12",   1, 0, 32'h12, 32'h0,        F_H,  32'hFFFF80AD, 0);
    applyStimulus("lhu_10",  1, 0, 32'h10, 32'h0,        F_HU, 32'h0000BEEF, 0);
    applyStimulus("lb_10",   1, 0, 32'h10, 32'h0,        F_B,  32'hFFFFFFEF, 0);
    applyStimulus("lbu_11",  1, 0, 32'h11, 32'h0,        F_BU, 32'h000000BE, 0);
    applyStimulus("sh_16",   0, 1, 32'h16, 32'hABCD7777, F_H,  32'h0,        0);
    applyStimulus("lhu_16",  1, 0, 32'h16, 32'h0,        F_HU, 32'h00007777, 0);
    applyStimulus("lb_17",   1, 0, 32'h17, 32'h0,        F_B,  32'h00000077, 0);

    applyStimulus("lw_12_err",  1, 0, 32'h12, 32'h0,        F_W,    32'h0, 1);
    applyStimulus("sh_11_err",  0, 1, 32'h11, 32'h0000FFFF, F_H,    32'h0, 1);
    applyStimulus("lw_10_keep", 1, 0, 32'h10, 32'h0,        F_W,    32'h80ADBEEF, 0);
    applyStimulus("f3_011_err", 1, 0, 32'h10, 32'h0,        3'b011, 32'h0, 1);
    applyStimulus("sbu_err",    0, 1, 32'h10, 32'h0,        F_BU,   32'h0, 1);
    applyStimulus("lh_13_err",  1, 0, 32'h13, 32'h0,        F_H,    32'h0, 1);
    applyStimulus("lw_10_keep2",1, 0, 32'h10, 32'h0,        F_W,    32'h80ADBEEF, 0);

    applyStimulus("both_sw_24", 1, 1, 32'h24, 32'hCAFEF00D, F_W, 32'h0,        0);
    applyStimulus("lw_24",      1, 0, 32'h24, 32'h0,        F_W, 32'hCAFEF00D, 0);

    applyStimulus("sw_1000",    0, 1, 32'h1000,     32'h00001234, F_W, 32'h0,        0);
    applyStimulus("lw_0000",    1, 0, 32'h0,        32'h0,        F_W, 32'h00001234, 0);
    applyStimulus("lw_hi_10",   1, 0, 32'hABC00010, 32'h0,        F_W, 32'h80ADBEEF, 0);

    // Zero-wait instance: store, then a load presented during the store's RESP cycle.
    @(negedge clk);
    z_mem_write = 1'b1;
    z_addr      = 32'h40;
    z_wdata     = 32'h600DF00D;
    z_funct3    = F_W;
    e = '{rdata: 32'h0, err: 1'b0, chk_data: 1'b0};
    q_zero.push_back(e);
    q_zero_tag.push_back("z_sw_40");
    @(posedge clk);
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      checkOutput($sformatf("z_ready_busy_c%0d", i), {30'd0, z_ready, z_busy}, {30'd0, z_pat[i]});
      if (i == 0) begin
        z_mem_write = 1'b0;
        z_mem_read  = 1'b1;
        e = '{rdata: 32'h600DF00D, err: 1'b0, chk_data: 1'b1};
        q_zero.push_back(e);
        q_zero_tag.push_back("z_lw_40");
      end
      if (i == 2) z_mem_read = 1'b0;
      @(posedge clk);
    end

    // Reset during the wait state of a store must abort it without writing.
    applyStimulus("sw_20", 0, 1, 32'h20, 32'h11111111, F_W, 32'h0,        0);
    applyStimulus("lw_20", 1, 0, 32'h20, 32'h0,        F_W, 32'h11111111, 0);
    @(negedge clk);
    mem_write = 1'b1;
    addr      = 32'h20;
    wdata     = 32'h00000055;
    funct3    = F_W;
    @(posedge clk);
    #2;
    checkOutput("rst_pre_busy", 32'(busy), 32'd1);
    rst_n = 1'b0;
    #1;
    checkOutput("rst_busy",    32'(busy),  32'd0);
    checkOutput("rst_ready",   32'(ready), 32'd0);
    checkOutput("rst_err",     32'(err),   32'd0);
    checkOutput("rst_rdata",   rdata,      32'd0);
    checkOutput("rst_z_rdata", z_rdata,    32'd0);
    mem_write = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    applyStimulus("lw_20_after_rst", 1, 0, 32'h20, 32'h0, F_W, 32'h11111111, 0);

    repeat (3) @(negedge clk);
    checkOutput("main_queue_drained", 32'(q_main.size()), 32'd0);
    checkOutput("zero_queue_drained", 32'(q_zero.size()), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
